// File: rtl/cfu_pkg.sv
// Shared CFU definitions: status codes, default channel widths and the
// scoreboard watchdog state encoding.
package cfu_pkg;

    localparam int CFU_STATUS_W      = 3;
    localparam int CFU_REQ_RESP_ID_W = 6;
    localparam int CFU_RESP_DATA_W   = 32;

    localparam logic [CFU_STATUS_W-1:0] CFU_STATUS_OK    = 3'd0;
    localparam logic [CFU_STATUS_W-1:0] CFU_STATUS_ERROR = 3'd1;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_WAIT,
        WD_TIMED_OUT
    } wd_state_e;

endpackage

// File: rtl/cfu_sb_fifo.sv
// Expected-result FIFO for the response scoreboard. Head is read from the
// registered read pointer, so an entry pushed this cycle is never visible.
module cfu_sb_fifo #(
    parameter int ID_W   = cfu_pkg::CFU_REQ_RESP_ID_W,
    parameter int DATA_W = cfu_pkg::CFU_RESP_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [ID_W+DATA_W-1:0]   wdata_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [ID_W+DATA_W-1:0]   head_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ID_W + DATA_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push, do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/cfu_resp_scoreboard.sv
// In-order response checker for a CFU under test: compares each accepted
// response against queued expectations and keeps saturating error counters.
module cfu_resp_scoreboard #(
    parameter int CFU_REQ_RESP_ID_W = cfu_pkg::CFU_REQ_RESP_ID_W,
    parameter int CFU_RESP_DATA_W   = cfu_pkg::CFU_RESP_DATA_W,
    parameter int CFU_STATUS_W      = cfu_pkg::CFU_STATUS_W,
    parameter int DEPTH             = 8,
    parameter int TIMEOUT           = 255,
    parameter int CNT_W             = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [CFU_REQ_RESP_ID_W-1:0] exp_id,
    input  logic [CFU_RESP_DATA_W-1:0]   exp_data,
    input  logic                         resp_valid,
    output logic                         resp_ready,
    input  logic [CFU_REQ_RESP_ID_W-1:0] resp_id,
    input  logic [CFU_STATUS_W-1:0]      resp_status,
    input  logic [CFU_RESP_DATA_W-1:0]   resp_data,
    input  logic                         bp_en,
    input  logic [15:0]                  lfsr,
    output logic [CNT_W-1:0]             match_count,
    output logic [CNT_W-1:0]             mismatch_count,
    output logic [CNT_W-1:0]             unexpected_count,
    output logic [$clog2(DEPTH):0]       outstanding,
    output logic [CFU_REQ_RESP_ID_W-1:0] last_bad_id,
    output logic                         timeout,
    output logic                         fail
);

    import cfu_pkg::*;

    localparam int ENTRY_W = CFU_REQ_RESP_ID_W + CFU_RESP_DATA_W;
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    logic                         fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]           head;
    logic                         accept, pop, resp_match;
    logic [CNT_W-1:0]             match_q, match_d;
    logic [CNT_W-1:0]             mismatch_q, mismatch_d;
    logic [CNT_W-1:0]             unexp_q, unexp_d;
    logic [CFU_REQ_RESP_ID_W-1:0] last_bad_q, last_bad_d;
    logic                         fail_q, fail_d;
    wd_state_e                    state_q, state_d;
    logic [IDLE_W-1:0]            idle_q, idle_d;
    logic                         unused_lfsr;

    assign unused_lfsr = ^lfsr[15:1];

    assign exp_ready  = ~fifo_full;
    assign resp_ready = ~bp_en | lfsr[0];
    assign accept     = resp_valid & resp_ready;
    assign pop        = accept & ~fifo_empty;
    assign resp_match = (resp_id == head[ENTRY_W-1:CFU_RESP_DATA_W])
                      && (resp_status == CFU_STATUS_W'(CFU_STATUS_OK))
                      && (resp_data == head[CFU_RESP_DATA_W-1:0]);

    cfu_sb_fifo #(
        .ID_W   (CFU_REQ_RESP_ID_W),
        .DATA_W (CFU_RESP_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (exp_valid),
        .wdata_i ({exp_id, exp_data}),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding),
        .head_o  (head)
    );

    // One count per accepted response; counters stick at all-ones.
    always_comb begin
        match_d    = match_q;
        mismatch_d = mismatch_q;
        unexp_d    = unexp_q;
        last_bad_d = last_bad_q;
        if (pop) begin
            if (resp_match) begin
                if (match_q != '1) match_d = match_q + CNT_W'(1);
            end else begin
                if (mismatch_q != '1) mismatch_d = mismatch_q + CNT_W'(1);
                last_bad_d = resp_id;
            end
        end else if (accept) begin
            if (unexp_q != '1) unexp_d = unexp_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            WD_IDLE: begin
                idle_d = '0;
                if (!fifo_empty) state_d = WD_WAIT;
            end
            WD_WAIT: begin
                if (fifo_empty) begin
                    state_d = WD_IDLE;
                end else if (accept) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) state_d = WD_TIMED_OUT;
                end
            end
            WD_TIMED_OUT: state_d = WD_TIMED_OUT;
            default:      state_d = WD_IDLE;
        endcase
    end

    // fail rises together with timeout so both are visible on the same cycle.
    assign fail_d = fail_q | (pop & ~resp_match) | (accept & fifo_empty)
                  | (state_d == WD_TIMED_OUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            match_q    <= '0;
            mismatch_q <= '0;
            unexp_q    <= '0;
            last_bad_q <= '0;
            fail_q     <= 1'b0;
            state_q    <= WD_IDLE;
            idle_q     <= '0;
        end else begin
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            unexp_q    <= unexp_d;
            last_bad_q <= last_bad_d;
            fail_q     <= fail_d;
            state_q    <= state_d;
            idle_q     <= idle_d;
        end
    end

    assign match_count      = match_q;
    assign mismatch_count   = mismatch_q;
    assign unexpected_count = unexp_q;
    assign last_bad_id      = last_bad_q;
    assign timeout          = (state_q == WD_TIMED_OUT);
    assign fail             = fail_q;

endmodule
